// File: rtl/puf_ro_reader.sv
`default_nettype none
// ============================================================================
//  Module   : puf_ro_reader
//  Brief    : Ring-oscillator PUF readout. Counts synchronized oscillator edges
//             over two gated windows (one per challenge), compares the counts.
//  Revision : 1.0 - initial release
// ============================================================================
module puf_ro_reader #(
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       chal_a,
    input  logic [1:0]       chal_b,
    input  logic             puf_osc,
    output logic             puf_enable,
    output logic [1:0]       puf_control,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic             tie,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int c_MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int c_TMR_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam logic [c_TMR_W-1:0] c_GATE_LD   = c_TMR_W'(GATE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_SETTLE_LD = c_TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE_A = 3'd1,
        ST_MEAS_A   = 3'd2,
        ST_SETTLE_B = 3'd3,
        ST_MEAS_B   = 3'd4,
        ST_CMP      = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_TMR_W-1:0]   w_timer_nxt;
    logic                 w_accept;
    logic [1:0]           r_chal_a;
    logic [1:0]           r_chal_b;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 r_sync_prev;
    logic                 w_rise;
    logic [CNT_W-1:0]     r_cnt_a;
    logic [CNT_W-1:0]     r_cnt_b;
    logic [CNT_W-1:0]     w_cnt_a_nxt;
    logic [CNT_W-1:0]     w_cnt_b_nxt;
    logic                 w_load;
    logic                 r_done;
    logic                 r_response;
    logic                 r_tie;
    logic [CNT_W-1:0]     r_count_a;
    logic [CNT_W-1:0]     r_count_b;

    // Synchronizer plus one history flop; an edge is a 0->1 step of the last stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], puf_osc};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_sync_prev;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_accept    = 1'b0;
        puf_enable  = 1'b0;
        puf_control = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE_A;
                    w_timer_nxt = c_SETTLE_LD;
                    w_accept    = 1'b1;
                end
            end
            ST_SETTLE_A, ST_MEAS_A: begin
                puf_enable  = 1'b1;
                puf_control = r_chal_a;
                if (r_timer == '0) begin
                    w_state_nxt = (r_state == ST_SETTLE_A) ? ST_MEAS_A : ST_SETTLE_B;
                    w_timer_nxt = (r_state == ST_SETTLE_A) ? c_GATE_LD : c_SETTLE_LD;
                end else begin
                    w_timer_nxt = r_timer - c_TMR_W'(1);
                end
            end
            ST_SETTLE_B, ST_MEAS_B: begin
                puf_enable  = 1'b1;
                puf_control = r_chal_b;
                if (r_timer == '0) begin
                    w_state_nxt = (r_state == ST_SETTLE_B) ? ST_MEAS_B : ST_CMP;
                    w_timer_nxt = (r_state == ST_SETTLE_B) ? c_GATE_LD : '0;
                end else begin
                    w_timer_nxt = r_timer - c_TMR_W'(1);
                end
            end
            ST_CMP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_chal_a <= 2'b00;
            r_chal_b <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            if (w_accept) begin
                r_chal_a <= chal_a;
                r_chal_b <= chal_b;
            end
        end
    end

    // Saturating edge counters, cleared when a read is accepted.
    always_comb begin
        w_cnt_a_nxt = r_cnt_a;
        w_cnt_b_nxt = r_cnt_b;
        if (w_accept) begin
            w_cnt_a_nxt = '0;
            w_cnt_b_nxt = '0;
        end else if (w_rise) begin
            if (r_state == ST_MEAS_A && r_cnt_a != c_CNT_MAX)
                w_cnt_a_nxt = r_cnt_a + CNT_W'(1);
            if (r_state == ST_MEAS_B && r_cnt_b != c_CNT_MAX)
                w_cnt_b_nxt = r_cnt_b + CNT_W'(1);
        end
    end

    // Results are registered on entry to CMP so they are valid while done is high.
    assign w_load = (r_state == ST_MEAS_B) && (w_state_nxt == ST_CMP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_done     <= 1'b0;
            r_response <= 1'b0;
            r_tie      <= 1'b0;
            r_count_a  <= '0;
            r_count_b  <= '0;
        end else begin
            r_cnt_a <= w_cnt_a_nxt;
            r_cnt_b <= w_cnt_b_nxt;
            r_done  <= w_load;
            if (w_load) begin
                r_count_a  <= w_cnt_a_nxt;
                r_count_b  <= w_cnt_b_nxt;
                r_response <= (w_cnt_a_nxt > w_cnt_b_nxt);
                r_tie      <= (w_cnt_a_nxt == w_cnt_b_nxt);
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign response = r_response;
    assign tie      = r_tie;
    assign count_a  = r_count_a;
    assign count_b  = r_count_b;

endmodule
`default_nettype wire
